// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver. Two binary values (clamped to 99) are converted to BCD
// by a sequential double-dabble. Define SEG7_LEADING_ZERO_BLANK_EN to blank zero tens digits.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value_a,
  input  logic [7:0] value_b,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] digit_select,
  output logic [1:0] o_dbg_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  logic [1:0]    r_state;
  logic [2:0]    r_shift_cnt;
  logic [15:0]   r_sr_a;
  logic [15:0]   r_sr_b;
  logic [7:0]    r_disp_a;
  logic [7:0]    r_disp_b;
  logic [CW-1:0] r_scan_cnt;
  logic [1:0]    r_digit_idx;
  logic [6:0]    r_seg;
  logic [3:0]    r_digit_select;

  logic [3:0]    w_digit;
  logic          w_blank;
  logic [6:0]    w_enc;

  function automatic logic [7:0] clamp99(input logic [7:0] v);
    return (v > 8'd99) ? 8'd99 : v;
  endfunction

  // Scratch layout is {tens, ones, binary}; one add-3 correction then one left shift.
  function automatic logic [15:0] dd_step(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    if (t[11:8] >= 4'd5)  t[11:8]  = t[11:8] + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    return {t[14:0], 1'b0};
  endfunction

  // Conversion FSM. The displayed registers change only in COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shift_cnt <= 3'd0;
      r_sr_a      <= 16'd0;
      r_sr_b      <= 16'd0;
      r_disp_a    <= 8'd0;
      r_disp_b    <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_sr_a      <= {8'd0, clamp99(value_a)};
            r_sr_b      <= {8'd0, clamp99(value_b)};
            r_shift_cnt <= 3'd0;
            r_state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_sr_a      <= dd_step(r_sr_a);
          r_sr_b      <= dd_step(r_sr_b);
          r_shift_cnt <= r_shift_cnt + 3'd1;
          if (r_shift_cnt == 3'd7) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_disp_a <= r_sr_a[15:8];
          r_disp_b <= r_sr_b[15:8];
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Free-running scan, independent of the conversion FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= 2'd0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= r_digit_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  always_comb begin
    w_digit = 4'd0;
    case (r_digit_idx)
      2'd0: w_digit = r_disp_b[3:0];
      2'd1: w_digit = r_disp_b[7:4];
      2'd2: w_digit = r_disp_a[3:0];
      2'd3: w_digit = r_disp_a[7:4];
      default: w_digit = 4'd0;
    endcase
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign w_blank = r_digit_idx[0] && (w_digit == 4'd0);
`else
  assign w_blank = 1'b0;
`endif

  // Active-low segments, bit order g..a.
  always_comb begin
    w_enc = 7'b1111111;
    case (w_digit)
      4'd0: w_enc = 7'b1000000;
      4'd1: w_enc = 7'b1111001;
      4'd2: w_enc = 7'b0100100;
      4'd3: w_enc = 7'b0110000;
      4'd4: w_enc = 7'b0011001;
      4'd5: w_enc = 7'b0010010;
      4'd6: w_enc = 7'b0000010;
      4'd7: w_enc = 7'b1111000;
      4'd8: w_enc = 7'b0000000;
      4'd9: w_enc = 7'b0010000;
      default: w_enc = 7'b1111111;
    endcase
  end

  // seg and digit_select share one register stage so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg          <= 7'b1111111;
      r_digit_select <= 4'b1111;
    end else begin
      r_seg          <= w_blank ? 7'b1111111 : w_enc;
      r_digit_select <= ~(4'b0001 << r_digit_idx);
    end
  end

  assign seg          = r_seg;
  assign digit_select = r_digit_select;
  assign busy         = (r_state != ST_IDLE);
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=4; expected segment patterns come from a
// local table and follow SEG7_LEADING_ZERO_BLANK_EN the same way the build does.
module tb_seg7_scan_driver;

  logic       clk;
  logic       reset;
  logic [7:0] value_a;
  logic [7:0] value_b;
  logic       load;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] digit_select;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_driver #(.SCAN_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .value_a      (value_a),
    .value_b      (value_b),
    .load         (load),
    .busy         (busy),
    .seg          (seg),
    .digit_select (digit_select),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] exp_seg(input int idx, input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if ((idx % 2 == 1) && d == 0) return 7'b1111111;
`endif
    return tbl[d];
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // driver tasks: act and sample 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [7:0] a, input logic [7:0] b);
    value_a = a;
    value_b = b;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [7:0] a, input logic [7:0] b);
    pulse_load(a, b);
    for (int i = 0; i < 9; i++) begin
      check({tag, "_busy_hi"}, {7'd0, busy}, 8'd1);
      if (i < 8) tick();
    end
    tick();
    check({tag, "_busy_lo"}, {7'd0, busy}, 8'd0);
  endtask

  // digits given as d3..d0 decimal values
  task automatic check_digits(input string tag, input int d3, input int d2, input int d1, input int d0);
    int dv [4];
    logic [3:0] want;
    dv = '{d0, d1, d2, d3};
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      want = ~(4'b0001 << i);
      for (int t = 0; t < 32 && digit_select !== want; t++) tick();
      check({tag, "_dsel"}, {4'd0, digit_select}, {4'd0, want});
      check($sformatf("%s_seg%0d", tag, i), {1'b0, seg}, {1'b0, exp_seg(i, dv[i])});
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; value_a = 8'd0; value_b = 8'd0;
    tick(); tick(); tick();
    check("rst_seg", {1'b0, seg}, 8'h7f);
    check("rst_dsel", {4'd0, digit_select}, 8'h0f);
    check("rst_busy", {7'd0, busy}, 8'd0);

    // scan sequencing after release: each digit held 4 clocks
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("scan_dsel", {4'd0, digit_select}, {4'd0, ~(4'b0001 << ((k / 4) % 4))});
      check("scan_seg", {1'b0, seg}, {1'b0, exp_seg((k / 4) % 4, 0)});
    end

    do_load("ld42_7", 8'd42, 8'd7);
    check_digits("d42_7", 4, 2, 0, 7);

    do_load("ld200_99", 8'd200, 8'd99);
    check_digits("d200_99", 9, 9, 9, 9);

    // second load three cycles into the first must be dropped
    pulse_load(8'd11, 8'd22);
    tick(); tick();
    value_a = 8'd33; value_b = 8'd44; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 3; i <= 8; i++) begin
      check("ign_busy_hi", {7'd0, busy}, 8'd1);
      if (i < 8) tick();
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ign_busy_lo", {7'd0, busy}, 8'd0);
    end
    check_digits("ign", 1, 1, 2, 2);

    // reset mid-conversion: nothing committed
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulse_load(8'd55, 8'd66);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    check("abort_busy", {7'd0, busy}, 8'd0);
    check("abort_seg", {1'b0, seg}, 8'h7f);
    check("abort_dsel", {4'd0, digit_select}, 8'h0f);
    reset = 1'b0;
    tick();
    check("abort_busy2", {7'd0, busy}, 8'd0);
    check_digits("abort", 0, 0, 0, 0);

    do_load("ld55_66", 8'd55, 8'd66);
    check_digits("d55_66", 5, 5, 6, 6);

    do_load("ld100_9", 8'd100, 8'd9);
    check_digits("d100_9", 9, 9, 0, 9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
